// File: rtl/dual_input_debouncer_if.sv
// Bundle of raw switch inputs and conditioned outputs for the dual-input debouncer.
// Latency: none (wires only).
// Backpressure: none; levels and pulses are free-running.
interface dual_input_debouncer_if #(
  parameter int GLITCH_W = 8
);
  logic                raw_a;
  logic                raw_b;
  logic                glitch_clr;
  logic                A;
  logic                B;
  logic                a_rise;
  logic                a_fall;
  logic                b_rise;
  logic                b_fall;
  logic [GLITCH_W-1:0] glitch_cnt;

  // Stimulus side: drives raw inputs and the glitch clear, observes conditioned outputs.
  modport master (
    output raw_a, raw_b, glitch_clr,
    input  A, B, a_rise, a_fall, b_rise, b_fall, glitch_cnt
  );

  // Debouncer side.
  modport slave (
    input  raw_a, raw_b, glitch_clr,
    output A, B, a_rise, a_fall, b_rise, b_fall, glitch_cnt
  );
endinterface

// File: rtl/dual_input_debouncer.sv
// Two-channel switch conditioner: 2-flop sync, per-channel debounce FSM, edge pulses, glitch count.
// Latency: a held level change appears on A/B (with its pulse) DEBOUNCE_CYCLES+2 edges after first sample.
// Backpressure: none; outputs are registered levels/pulses, glitch counter saturates.
module dual_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dual_input_debouncer_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int GS_W = GLITCH_W + 1;

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HI,
    S_HIGH,
    S_WAIT_LO
  } state_t;

  // Index 0 is channel A, index 1 is channel B throughout.
  logic [1:0]          w_raw;
  logic [1:0]          r_s1;
  logic [1:0]          r_s2;
  state_t              r_state     [2];
  state_t              w_state_nxt [2];
  logic [CNT_W-1:0]    r_cnt       [2];
  logic [CNT_W-1:0]    w_cnt_nxt   [2];
  logic [1:0]          r_lvl;
  logic [1:0]          w_lvl_nxt;
  logic [1:0]          r_rise;
  logic [1:0]          w_rise_nxt;
  logic [1:0]          r_fall;
  logic [1:0]          w_fall_nxt;
  logic [1:0]          w_glitch;
  logic [GLITCH_W-1:0] r_gcnt;
  logic [GS_W-1:0]     w_gsum;

  assign w_raw = {bus.raw_b, bus.raw_a};

  // Two-flop synchroniser per channel; the FSM only ever looks at r_s2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // FSM state, wait counter, debounced level and edge pulses register per channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        r_state[ch] <= S_LOW;
        r_cnt[ch]   <= '0;
      end
      r_lvl  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        r_cnt[ch]   <= w_cnt_nxt[ch];
      end
      r_lvl  <= w_lvl_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  // Next-state logic: a wait state needs DEBOUNCE_CYCLES+1 consecutive new-value samples;
  // one old-value sample aborts back to the stable state and flags a glitch.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_cnt_nxt[ch]   = r_cnt[ch];
      w_lvl_nxt[ch]   = r_lvl[ch];
      w_rise_nxt[ch]  = 1'b0;
      w_fall_nxt[ch]  = 1'b0;
      w_glitch[ch]    = 1'b0;
      case (r_state[ch])
        S_LOW: begin
          if (r_s2[ch]) begin
            w_state_nxt[ch] = S_WAIT_HI;
            w_cnt_nxt[ch]   = '0;
          end
        end
        S_WAIT_HI: begin
          if (!r_s2[ch]) begin
            w_state_nxt[ch] = S_LOW;
            w_glitch[ch]    = 1'b1;
          end else if (r_cnt[ch] == CNT_LAST) begin
            w_state_nxt[ch] = S_HIGH;
            w_lvl_nxt[ch]   = 1'b1;
            w_rise_nxt[ch]  = 1'b1;
          end else begin
            w_cnt_nxt[ch] = r_cnt[ch] + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!r_s2[ch]) begin
            w_state_nxt[ch] = S_WAIT_LO;
            w_cnt_nxt[ch]   = '0;
          end
        end
        S_WAIT_LO: begin
          if (r_s2[ch]) begin
            w_state_nxt[ch] = S_HIGH;
            w_glitch[ch]    = 1'b1;
          end else if (r_cnt[ch] == CNT_LAST) begin
            w_state_nxt[ch] = S_LOW;
            w_lvl_nxt[ch]   = 1'b0;
            w_fall_nxt[ch]  = 1'b1;
          end else begin
            w_cnt_nxt[ch] = r_cnt[ch] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[ch] = S_LOW;
        end
      endcase
    end
  end

  // One extra bit of headroom so a saturating add of up to 2 can detect overflow.
  assign w_gsum = {1'b0, r_gcnt} + GS_W'(w_glitch[0]) + GS_W'(w_glitch[1]);

  // Saturating glitch counter; clear wins over any same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gcnt <= '0;
    end else if (bus.glitch_clr) begin
      r_gcnt <= '0;
    end else if (w_gsum[GLITCH_W]) begin
      r_gcnt <= '1;
    end else begin
      r_gcnt <= w_gsum[GLITCH_W-1:0];
    end
  end

  assign bus.A          = r_lvl[0];
  assign bus.B          = r_lvl[1];
  assign bus.a_rise     = r_rise[0];
  assign bus.a_fall     = r_fall[0];
  assign bus.b_rise     = r_rise[1];
  assign bus.b_fall     = r_fall[1];
  assign bus.glitch_cnt = r_gcnt;

endmodule
